// File: rtl/mdl_salign_pkg.sv
// Shared types, comma constants and 8b/10b sub-block decode tables for the serial word aligner.
// Table helpers return {legal, value}; an unlisted code is reported as illegal.
package mdl_salign_pkg;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // abcdei -> {legal, EDCBA}; both K28 forms decode to 28
  function automatic logic [5:0] dec_5b6b(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: return {1'b1, 5'd0};
      6'b011101, 6'b100010: return {1'b1, 5'd1};
      6'b101101, 6'b010010: return {1'b1, 5'd2};
      6'b110001:            return {1'b1, 5'd3};
      6'b110101, 6'b001010: return {1'b1, 5'd4};
      6'b101001:            return {1'b1, 5'd5};
      6'b011001:            return {1'b1, 5'd6};
      6'b111000, 6'b000111: return {1'b1, 5'd7};
      6'b111001, 6'b000110: return {1'b1, 5'd8};
      6'b100101:            return {1'b1, 5'd9};
      6'b010101:            return {1'b1, 5'd10};
      6'b110100:            return {1'b1, 5'd11};
      6'b001101:            return {1'b1, 5'd12};
      6'b101100:            return {1'b1, 5'd13};
      6'b011100:            return {1'b1, 5'd14};
      6'b010111, 6'b101000: return {1'b1, 5'd15};
      6'b011011, 6'b100100: return {1'b1, 5'd16};
      6'b100011:            return {1'b1, 5'd17};
      6'b010011:            return {1'b1, 5'd18};
      6'b110010:            return {1'b1, 5'd19};
      6'b001011:            return {1'b1, 5'd20};
      6'b101010:            return {1'b1, 5'd21};
      6'b011010:            return {1'b1, 5'd22};
      6'b111010, 6'b000101: return {1'b1, 5'd23};
      6'b110011, 6'b001100: return {1'b1, 5'd24};
      6'b100110:            return {1'b1, 5'd25};
      6'b010110:            return {1'b1, 5'd26};
      6'b110110, 6'b001001: return {1'b1, 5'd27};
      6'b001110, 6'b001111,
      6'b110000:            return {1'b1, 5'd28};
      6'b101110, 6'b010001: return {1'b1, 5'd29};
      6'b011110, 6'b100001: return {1'b1, 5'd30};
      6'b101011, 6'b010100: return {1'b1, 5'd31};
      default:              return 6'd0;
    endcase
  endfunction

  // fghj -> {legal, HGF}; caller pre-inverts fghj after the RD+ K28 prefix
  function automatic logic [3:0] dec_3b4b(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100:                   return {1'b1, 3'd0};
      4'b1001:                            return {1'b1, 3'd1};
      4'b0101:                            return {1'b1, 3'd2};
      4'b1100, 4'b0011:                   return {1'b1, 3'd3};
      4'b1101, 4'b0010:                   return {1'b1, 3'd4};
      4'b1010:                            return {1'b1, 3'd5};
      4'b0110:                            return {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: return {1'b1, 3'd7};
      default:                            return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdl_s10b8b_byte.sv
// Single 10b slice decoder: data byte, K flag, illegal flag and next running disparity.
// Purely combinational; no backpressure. MDL_SALIGN_DISPARITY_EN adds RD-consistency checking.
module mdl_s10b8b_byte
  import mdl_salign_pkg::*;
(
  input  logic [9:0] i_code,
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_k,
  output logic       o_illegal,
  output logic       o_rd
);

  logic [5:0] w_6b;
  logic [3:0] w_4b;
  logic [5:0] w_d6;
  logic [3:0] w_d4;
  logic [2:0] w_n6;
  logic [2:0] w_n4;
  logic       w_rd6;
  logic       w_kx7;

  assign w_6b = i_code[9:4];
  assign w_4b = i_code[3:0];
  assign w_d6 = dec_5b6b(w_6b);
  // K28 RD+ carries the complemented fghj of its RD- form
  assign w_d4 = dec_3b4b((w_6b == 6'b110000) ? ~w_4b : w_4b);
  assign w_n6 = 3'($countones(w_6b));
  assign w_n4 = 3'($countones(w_4b));

  assign w_rd6 = (w_n6 > 3'd3) ? 1'b1 : (w_n6 < 3'd3) ? 1'b0 : i_rd;
  assign o_rd  = (w_n4 > 3'd2) ? 1'b1 : (w_n4 < 3'd2) ? 1'b0 : w_rd6;

  assign w_kx7 = (w_6b inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                               6'b101110, 6'b010001, 6'b011110, 6'b100001})
               && (w_4b inside {4'b0111, 4'b1000});
  assign o_k    = (w_6b == 6'b001111) || (w_6b == 6'b110000) || w_kx7;
  assign o_data = {w_d4[2:0], w_d6[4:0]};

`ifdef MDL_SALIGN_DISPARITY_EN
  logic w_bad6;
  logic w_bad4;
  assign w_bad6 = ((w_n6 > 3'd3) && i_rd) || ((w_n6 < 3'd3) && !i_rd)
                || ((w_6b == 6'b111000) && i_rd) || ((w_6b == 6'b000111) && !i_rd);
  assign w_bad4 = ((w_n4 > 3'd2) && w_rd6) || ((w_n4 < 3'd2) && !w_rd6)
                || ((w_4b == 4'b1100) && w_rd6) || ((w_4b == 4'b0011) && !w_rd6);
  assign o_illegal = !w_d6[5] || !w_d4[3] || w_bad6 || w_bad4;
`else
  assign o_illegal = !w_d6[5] || !w_d4[3];
`endif

endmodule

// File: rtl/mdl_salign_n.sv
// Serial 8b/10b word aligner: hunts K28.5 in byte 0, confirms LOCK_CNT words, emits NB decoded bytes.
// Latency: o_valid/o_err one clock after the word-boundary cycle; no backpressure (one line bit per clock).
// MDL_SALIGN_DISPARITY_EN enables running-disparity checking and RD-specific comma matching.
module mdl_salign_n
  import mdl_salign_pkg::*;
#(
  parameter int NB       = 4,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 4
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_p,
  output logic              o_valid,
  output logic [8*NB-1:0]   o_data,
  output logic [NB-1:0]     o_ctrl,
  output logic              o_locked,
  output logic              o_err
);

  localparam int W  = 10*NB;
  localparam int OW = $clog2(W);
  localparam int GW = $clog2(LOCK_CNT+1);
  localparam int BW = $clog2(LOSS_CNT+1);

  logic [W-1:0]    r_sr;
  logic [OW-1:0]   r_off;
  state_t          r_state;
  logic [GW-1:0]   r_good;
  logic [BW-1:0]   r_bad;
  logic            r_rd;
  logic            r_valid;
  logic            r_err;
  logic            r_locked;
  logic [8*NB-1:0] r_data;
  logic [NB-1:0]   r_ctrl;

  logic [NB:0]     w_rd;
  logic [8*NB-1:0] w_data;
  logic [NB-1:0]   w_ctrl;
  logic [NB-1:0]   w_ill;
  logic            w_legal;
  logic            w_comma;
  logic            w_boundary;
  logic [OW-1:0]   w_off_nxt;

  // byte 0 is the oldest slice, at the MSB end; disparity chains in byte order
  assign w_rd[0] = r_rd;
  for (genvar g = 0; g < NB; g++) begin : g_dec
    mdl_s10b8b_byte u_dec (
      .i_code    (r_sr[W-1-10*g -: 10]),
      .i_rd      (w_rd[g]),
      .o_data    (w_data[8*g +: 8]),
      .o_k       (w_ctrl[g]),
      .o_illegal (w_ill[g]),
      .o_rd      (w_rd[g+1])
    );
  end

  assign w_legal    = ~|w_ill;
  assign w_boundary = (r_off == '0);
  assign w_off_nxt  = (r_off == OW'(W-1)) ? '0 : r_off + 1'b1;
`ifdef MDL_SALIGN_DISPARITY_EN
  assign w_comma = (r_sr[W-1 -: 10] == (r_rd ? K28_5_RDP : K28_5_RDN));
`else
  assign w_comma = (r_sr[W-1 -: 10] == K28_5_RDN) || (r_sr[W-1 -: 10] == K28_5_RDP);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sr     <= '0;
      r_off    <= '0;
      r_state  <= HUNT;
      r_good   <= '0;
      r_bad    <= '0;
      r_rd     <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_data   <= '0;
      r_ctrl   <= '0;
    end else begin
      r_sr    <= {r_sr[W-2:0], i_rx_p};
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        HUNT: begin
          r_off <= '0;
          if (w_comma && w_legal) begin
            r_state <= CHECK;
            r_off   <= OW'(1);
            r_good  <= '0;
            r_rd    <= w_rd[NB];
          end
        end
        CHECK: begin
          r_off <= w_off_nxt;
          if (w_boundary) begin
            if (w_legal) begin
              r_rd <= w_rd[NB];
              if (r_good != GW'(LOCK_CNT)) r_good <= r_good + 1'b1;
              if (r_good >= GW'(LOCK_CNT-1)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end
            end else begin
              r_state <= HUNT;
              r_off   <= '0;
              r_rd    <= 1'b0;
              r_good  <= '0;
            end
          end
        end
        LOCKED: begin
          r_off <= w_off_nxt;
          if (w_boundary) begin
            r_rd <= w_rd[NB];
            if (w_legal) begin
              r_valid <= 1'b1;
              r_data  <= w_data;
              r_ctrl  <= w_ctrl;
              r_bad   <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_bad != BW'(LOSS_CNT)) r_bad <= r_bad + 1'b1;
              // a comma elsewhere never realigns; only loss of lock returns to HUNT
              if (r_bad >= BW'(LOSS_CNT-1)) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_data   <= '0;
                r_ctrl   <= '0;
                r_rd     <= 1'b0;
                r_off    <= '0;
                r_good   <= '0;
              end
            end
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_ctrl   = r_ctrl;
  assign o_locked = r_locked;
  assign o_err    = r_err;

endmodule
